// File: rtl/ntt_job_sched.sv
// Round-robin scheduler that shares one NTT and one INTT engine between two requesters.
// It sequences pair reads into the active engine, collects its output strobes and flags completion or timeout.
module ntt_job_sched #(
   parameter int N_PAIRS = 128,
   parameter int ADDR_W  = 7,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   output logic [1:0]        ack,
   output logic [1:0]        done,
   output logic              busy,
   output logic              err,
   input  logic              stall,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              ntt_in_en,
   output logic              intt_in_en,
   input  logic              ntt_out_en,
   input  logic              intt_out_en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(N_PAIRS - 1);
   localparam logic [15:0]       TMO       = 16'(TIMEOUT);

   state_t            state_q, state_d;
   logic              sel_q, sel_d;
   logic              last_q, last_d;
   logic [ADDR_W-1:0] issue_cnt_q, issue_cnt_d;
   logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
   logic [15:0]       idle_cnt_q, idle_cnt_d;
   logic [1:0]        ack_q, ack_d;
   logic [1:0]        done_q, done_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;
   logic              ntt_in_en_q, ntt_in_en_d;
   logic              intt_in_en_q, intt_in_en_d;

   logic act_out, stray_out, job_live, accept, err_set, grant;

   // Strobes are only meaningful while a job owns an engine; anything else is flagged and dropped.
   assign job_live  = (state_q == ISSUE) || (state_q == DRAIN);
   assign act_out   = sel_q ? intt_out_en : ntt_out_en;
   assign stray_out = sel_q ? ntt_out_en : intt_out_en;
   assign accept    = job_live && act_out;
   assign err_set   = stray_out || (!job_live && (ntt_out_en || intt_out_en));

   assign rd_en      = (state_q == ISSUE) && !stall;
   assign rd_addr    = issue_cnt_q;
   assign wr_en      = accept;
   assign wr_addr    = out_cnt_q;
   assign ack        = ack_q;
   assign done       = done_q;
   assign busy       = busy_q;
   assign err        = err_q;
   assign ntt_in_en  = ntt_in_en_q;
   assign intt_in_en = intt_in_en_q;

   always_comb begin
      // NOTE: every variable gets a default here so no path can leave it unassigned and infer a latch.
      state_d      = state_q;
      sel_d        = sel_q;
      last_d       = last_q;
      issue_cnt_d  = issue_cnt_q;
      out_cnt_d    = out_cnt_q;
      idle_cnt_d   = idle_cnt_q;
      ack_d        = 2'b00;
      done_d       = 2'b00;
      err_d        = err_q || err_set;
      grant        = 1'b0;
      ntt_in_en_d  = rd_en && !sel_q;
      intt_in_en_d = rd_en && sel_q;

      if (accept) out_cnt_d = out_cnt_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               grant       = (req == 2'b11) ? !last_q : req[1];
               state_d     = ISSUE;
               sel_d       = grant;
               last_d      = grant;
               ack_d       = grant ? 2'b10 : 2'b01;
               issue_cnt_d = '0;
               out_cnt_d   = '0;
               idle_cnt_d  = '0;
            end
         end
         ISSUE: begin
            idle_cnt_d = '0;
            if (rd_en) begin
               issue_cnt_d = issue_cnt_q + 1'b1;
               if (issue_cnt_q == LAST_PAIR) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (accept) begin
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 16'd1;
               if (idle_cnt_d == TMO) begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // The final accepted strobe wins over any timeout or issue transition in the same cycle.
      if (accept && (out_cnt_q == LAST_PAIR)) begin
         state_d = DONE;
         done_d  = sel_q ? 2'b10 : 2'b01;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         sel_q        <= 1'b0;
         last_q       <= 1'b1;
         issue_cnt_q  <= '0;
         out_cnt_q    <= '0;
         idle_cnt_q   <= '0;
         ack_q        <= 2'b00;
         done_q       <= 2'b00;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         ntt_in_en_q  <= 1'b0;
         intt_in_en_q <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the values from before this edge.
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_q       <= last_d;
         issue_cnt_q  <= issue_cnt_d;
         out_cnt_q    <= out_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
         ack_q        <= ack_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         ntt_in_en_q  <= ntt_in_en_d;
         intt_in_en_q <= intt_in_en_d;
      end
   end

endmodule
